// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC types and constants.
//   flit_label_t   : flit position within a packet (HEAD, BODY, TAIL, HEADTAIL)
//   flit_t         : link flit = label + payload
//   VC_NUM         : number of virtual channels per port
//   ALLOC_HOLDOFF_DEFAULT : cycles a VC stays unallocatable after its tail leaves
//   vc_state_t     : per-VC wormhole state (idle / mid-packet)
package noc_pkg;

    localparam int VC_NUM                = 4;
    localparam int FLIT_PAYLOAD_W        = 16;
    localparam int ALLOC_HOLDOFF_DEFAULT = 2;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        flit_label_t               label;
        logic [FLIT_PAYLOAD_W-1:0] payload;
    } flit_t;

    typedef enum logic {
        VC_IDLE   = 1'b0,
        VC_ACTIVE = 1'b1
    } vc_state_t;

    // True for flits that open a new packet and therefore need allocation.
    function automatic logic is_head_label(input flit_label_t label);
        return (label == HEAD) || (label == HEADTAIL);
    endfunction

endpackage

// File: rtl/output_link_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin arbiter over N requesters.
//   clk, rst : clock, asynchronous active-high reset (pointer -> 0)
//   req      : request vector
//   advance  : move pointer past the current winner at the next edge
//   grant    : one-hot (or zero) combinational grant; search starts at the pointer
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win_idx;
    logic          found;

    always_comb begin
        int unsigned k;
        grant   = '0;
        win_idx = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                win_idx  = PW'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= PW'((int'(win_idx) + 1) % N);
        end
    end

endmodule

// File: rtl/output_link_scheduler.sv
// output_link_scheduler: shares one router-to-router link among VC_NUM local VCs.
//   clk, rst          : clock, asynchronous active-high reset
//   req_i             : VC v has a flit at flit_i[v]
//   flit_i            : head-of-queue flit per VC
//   grant_o           : combinational pop strobe, one-hot or zero
//   data_o            : registered flit to the link
//   is_valid_o        : registered link valid
//   is_on_off_i       : downstream VC v can accept flits
//   is_allocatable_i  : downstream VC v is free for a new packet
//   active_o          : debug, VC v is mid-packet
// Handshake: a flit leaves VC v exactly when grant_o[v]=1 in that cycle; the
// buffer pops on that strobe and the flit appears on data_o with is_valid_o=1
// one cycle later. There is no backpressure on the link itself; flow control is
// entirely through is_on_off_i / is_allocatable_i.
module output_link_scheduler
    import noc_pkg::*;
#(
    parameter int VC_NUM        = noc_pkg::VC_NUM,
    parameter int ALLOC_HOLDOFF = noc_pkg::ALLOC_HOLDOFF_DEFAULT  // 0..7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [VC_NUM-1:0] req_i,
    input  flit_t             flit_i [VC_NUM],
    output logic [VC_NUM-1:0] grant_o,
    output flit_t             data_o,
    output logic              is_valid_o,
    input  logic [VC_NUM-1:0] is_on_off_i,
    input  logic [VC_NUM-1:0] is_allocatable_i,
    output logic [VC_NUM-1:0] active_o
);

    vc_state_t         state [VC_NUM];
    logic [2:0]        hcnt  [VC_NUM];
    logic [VC_NUM-1:0] elig;
    logic [VC_NUM-1:0] grant;
    flit_t             sel_flit;

    // Mid-packet VCs only need on/off credit; idle VCs additionally need a
    // head flit, a free downstream VC and an expired holdoff.
    always_comb begin
        elig = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            if (req_i[v] && is_on_off_i[v]) begin
                if (state[v] == VC_ACTIVE) begin
                    elig[v] = 1'b1;
                end else if (is_head_label(flit_i[v].label) &&
                             is_allocatable_i[v] && (hcnt[v] == 3'd0)) begin
                    elig[v] = 1'b1;
                end
            end
        end
    end

    rr_arbiter #(.N(VC_NUM)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (elig),
        .advance (|grant),
        .grant   (grant)
    );

    assign grant_o = grant;

    always_comb begin
        sel_flit = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            if (grant[v]) sel_flit = flit_i[v];
        end
    end

    always_comb begin
        active_o = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            active_o[v] = (state[v] == VC_ACTIVE);
        end
    end

    // Link output register: data_o holds its last value when nothing is sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_o     <= '0;
            is_valid_o <= 1'b0;
        end else begin
            is_valid_o <= |grant;
            if (|grant) data_o <= sel_flit;
        end
    end

    // Per-VC wormhole state and post-tail holdoff. hcnt is reloaded only on a
    // TAIL/HEADTAIL grant, so a reload never collides with a head grant on the
    // same VC (a head needs hcnt==0 and the VC idle).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                state[v] <= VC_IDLE;
                hcnt[v]  <= 3'd0;
            end
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (hcnt[v] != 3'd0) hcnt[v] <= hcnt[v] - 3'd1;
                if (grant[v]) begin
                    unique case (flit_i[v].label)
                        HEAD:     state[v] <= VC_ACTIVE;
                        BODY:     state[v] <= VC_ACTIVE;
                        TAIL: begin
                            state[v] <= VC_IDLE;
                            hcnt[v]  <= 3'(ALLOC_HOLDOFF);
                        end
                        HEADTAIL: begin
                            state[v] <= VC_IDLE;
                            hcnt[v]  <= 3'(ALLOC_HOLDOFF);
                        end
                    endcase
                end
            end
        end
    end

    // An idle VC offering BODY/TAIL means its upstream buffer lost a head.
    // It is simply never eligible; this only reports it.
    for (genvar g = 0; g < VC_NUM; g++) begin : g_proto_chk
        always @(posedge clk) begin
            if (!rst) begin
                assert (!(req_i[g] && (state[g] == VC_IDLE) &&
                          !is_head_label(flit_i[g].label)))
                else $warning("protocol error: idle VC %0d presented a non-head flit", g);
            end
        end
    end

endmodule

// File: tb/tb_output_link_scheduler.sv
module tb_output_link_scheduler;
    import noc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    flit_t       flit [4];
    logic [3:0]  grant;
    flit_t       data;
    logic        is_valid;
    logic [3:0]  on_off;
    logic [3:0]  alloc;
    logic [3:0]  active;

    int compared   = 0;
    int mismatched = 0;

    output_link_scheduler #(.VC_NUM(4), .ALLOC_HOLDOFF(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_i            (req),
        .flit_i           (flit),
        .grant_o          (grant),
        .data_o           (data),
        .is_valid_o       (is_valid),
        .is_on_off_i      (on_off),
        .is_allocatable_i (alloc),
        .active_o         (active)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic flit_t mk(input flit_label_t l, input logic [15:0] p);
        flit_t f;
        f.label   = l;
        f.payload = p;
        return f;
    endfunction

    // driver tasks: inputs change at posedge+1, checks happen at posedge+2
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = '0;
        repeat (n) next_cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; on_off = '1; alloc = '1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; on_off = '1; alloc = '1;
        for (int i = 0; i < 4; i++) flit[i] = '0;
        next_cycle(); #1;
        compared++; if (is_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", is_valid); end
        compared++; if (data !== flit_t'('0)) begin mismatched++; $display("FAIL reset_data: got %h want 0", data); end
        compared++; if (grant !== 4'b0000) begin mismatched++; $display("FAIL reset_grant: got %b want 0000", grant); end
        compared++; if (active !== 4'b0000) begin mismatched++; $display("FAIL reset_active: got %b want 0000", active); end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_headtail_holdoff();
        flit_t ht;
        ht = mk(HEADTAIL, 16'h00A1);
        next_cycle(); flit[0] = ht; req = 4'b0001; #1;
        compared++; if (grant !== 4'b0001) begin mismatched++; $display("FAIL ht_grant: got %b want 0001", grant); end
        next_cycle(); #1;
        compared++; if (is_valid !== 1'b1) begin mismatched++; $display("FAIL ht_valid: got %b want 1", is_valid); end
        compared++; if (data !== ht) begin mismatched++; $display("FAIL ht_data: got %h want %h", data, ht); end
        compared++; if (active[0] !== 1'b0) begin mismatched++; $display("FAIL ht_idle: got %b want 0", active[0]); end
        compared++; if (grant !== 4'b0000) begin mismatched++; $display("FAIL ht_hold1: got %b want 0000", grant); end
        next_cycle(); #1;
        compared++; if (grant !== 4'b0000) begin mismatched++; $display("FAIL ht_hold2: got %b want 0000", grant); end
        compared++; if (is_valid !== 1'b0) begin mismatched++; $display("FAIL ht_gap_valid: got %b want 0", is_valid); end
        next_cycle(); #1;
        compared++; if (grant !== 4'b0001) begin mismatched++; $display("FAIL ht_regrant: got %b want 0001", grant); end
        next_cycle(); req = '0; #1;
        compared++; if (is_valid !== 1'b1) begin mismatched++; $display("FAIL ht_regrant_valid: got %b want 1", is_valid); end
        idle(3);
    endtask

    task automatic test_on_off();
        next_cycle(); flit[1] = mk(HEAD, 16'h0B00); req = 4'b0010; #1;
        compared++; if (grant !== 4'b0010) begin mismatched++; $display("FAIL oo_head_grant: got %b want 0010", grant); end
        next_cycle(); flit[1] = mk(BODY, 16'h0B01); on_off[1] = 1'b0; #1;
        compared++; if (data !== mk(HEAD, 16'h0B00)) begin mismatched++; $display("FAIL oo_head_data: got %h want %h", data, mk(HEAD, 16'h0B00)); end
        compared++; if (is_valid !== 1'b1) begin mismatched++; $display("FAIL oo_head_valid: got %b want 1", is_valid); end
        compared++; if (grant !== 4'b0000) begin mismatched++; $display("FAIL oo_block0: got %b want 0000", grant); end
        compared++; if (active[1] !== 1'b1) begin mismatched++; $display("FAIL oo_active0: got %b want 1", active[1]); end
        for (int i = 1; i < 3; i++) begin
            next_cycle(); #1;
            compared++; if (grant !== 4'b0000) begin mismatched++; $display("FAIL oo_block%0d: got %b want 0000", i, grant); end
            compared++; if (active[1] !== 1'b1) begin mismatched++; $display("FAIL oo_active%0d: got %b want 1", i, active[1]); end
            compared++; if (is_valid !== 1'b0) begin mismatched++; $display("FAIL oo_idle_valid%0d: got %b want 0", i, is_valid); end
        end
        next_cycle(); on_off[1] = 1'b1; #1;
        compared++; if (grant !== 4'b0010) begin mismatched++; $display("FAIL oo_body1_grant: got %b want 0010", grant); end
        next_cycle(); flit[1] = mk(BODY, 16'h0B02); #1;
        compared++; if (data !== mk(BODY, 16'h0B01)) begin mismatched++; $display("FAIL oo_body1_data: got %h want %h", data, mk(BODY, 16'h0B01)); end
        compared++; if (grant !== 4'b0010) begin mismatched++; $display("FAIL oo_body2_grant: got %b want 0010", grant); end
        next_cycle(); flit[1] = mk(TAIL, 16'h0B03); #1;
        compared++; if (data !== mk(BODY, 16'h0B02)) begin mismatched++; $display("FAIL oo_body2_data: got %h want %h", data, mk(BODY, 16'h0B02)); end
        compared++; if (grant !== 4'b0010) begin mismatched++; $display("FAIL oo_tail_grant: got %b want 0010", grant); end
        compared++; if (active[1] !== 1'b1) begin mismatched++; $display("FAIL oo_active_pre_tail: got %b want 1", active[1]); end
        next_cycle(); req = '0; #1;
        compared++; if (data !== mk(TAIL, 16'h0B03)) begin mismatched++; $display("FAIL oo_tail_data: got %h want %h", data, mk(TAIL, 16'h0B03)); end
        compared++; if (active[1] !== 1'b0) begin mismatched++; $display("FAIL oo_active_post_tail: got %b want 0", active[1]); end
        idle(3);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        for (int v = 0; v < 4; v++) flit[v] = mk(HEADTAIL, 16'(v));
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) next_cycle();
            #1;
            exp_g = 4'b0001 << (i % 4);
            compared++; if (grant !== exp_g) begin mismatched++; $display("FAIL rr_grant%0d: got %b want %b", i, grant, exp_g); end
            if (i > 0) begin
                compared++; if (is_valid !== 1'b1) begin mismatched++; $display("FAIL rr_valid%0d: got %b want 1", i, is_valid); end
                compared++; if (data !== mk(HEADTAIL, 16'((i - 1) % 4))) begin mismatched++; $display("FAIL rr_data%0d: got %h want %h", i, data, mk(HEADTAIL, 16'((i - 1) % 4))); end
            end
        end
        next_cycle(); req = '0; #1;
        compared++; if (data !== mk(HEADTAIL, 16'd3)) begin mismatched++; $display("FAIL rr_last_data: got %h want %h", data, mk(HEADTAIL, 16'd3)); end
        idle(3);
    endtask

    task automatic test_alloc();
        next_cycle(); flit[2] = mk(HEAD, 16'h0C00); req = 4'b0100; alloc[2] = 1'b0; #1;
        compared++; if (grant !== 4'b0000) begin mismatched++; $display("FAIL al_block0: got %b want 0000", grant); end
        next_cycle(); #1;
        compared++; if (grant !== 4'b0000) begin mismatched++; $display("FAIL al_block1: got %b want 0000", grant); end
        next_cycle(); alloc[2] = 1'b1; #1;
        compared++; if (grant !== 4'b0100) begin mismatched++; $display("FAIL al_head_grant: got %b want 0100", grant); end
        next_cycle(); flit[2] = mk(BODY, 16'h0C01); alloc[2] = 1'b0; #1;
        compared++; if (grant !== 4'b0100) begin mismatched++; $display("FAIL al_body_grant: got %b want 0100", grant); end
        compared++; if (active[2] !== 1'b1) begin mismatched++; $display("FAIL al_active: got %b want 1", active[2]); end
        compared++; if (data !== mk(HEAD, 16'h0C00)) begin mismatched++; $display("FAIL al_head_data: got %h want %h", data, mk(HEAD, 16'h0C00)); end
        next_cycle(); flit[2] = mk(TAIL, 16'h0C02); #1;
        compared++; if (grant !== 4'b0100) begin mismatched++; $display("FAIL al_tail_grant: got %b want 0100", grant); end
        next_cycle(); req = '0; alloc = '1; #1;
        compared++; if (data !== mk(TAIL, 16'h0C02)) begin mismatched++; $display("FAIL al_tail_data: got %h want %h", data, mk(TAIL, 16'h0C02)); end
        compared++; if (active[2] !== 1'b0) begin mismatched++; $display("FAIL al_idle: got %b want 0", active[2]); end
        idle(3);
    endtask

    task automatic test_protocol_error();
        logic [3:0] exp_g [4];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0000; exp_g[2] = 4'b0000; exp_g[3] = 4'b0001;
        flit[3] = mk(BODY, 16'h0D01);
        flit[0] = mk(HEADTAIL, 16'h0D00);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            req = 4'b1001;
            #1;
            compared++; if (grant !== exp_g[i]) begin mismatched++; $display("FAIL pe_grant%0d: got %b want %b", i, grant, exp_g[i]); end
            compared++; if (active[3] !== 1'b0) begin mismatched++; $display("FAIL pe_vc3_idle%0d: got %b want 0", i, active[3]); end
        end
        idle(3);
    endtask

    task automatic test_reset_mid_packet();
        next_cycle(); flit[0] = mk(HEAD, 16'h0E00); req = 4'b0001; #1;
        compared++; if (grant !== 4'b0001) begin mismatched++; $display("FAIL rm_head_grant: got %b want 0001", grant); end
        next_cycle(); flit[0] = mk(BODY, 16'h0E01); #1;
        compared++; if (active[0] !== 1'b1) begin mismatched++; $display("FAIL rm_active: got %b want 1", active[0]); end
        compared++; if (is_valid !== 1'b1) begin mismatched++; $display("FAIL rm_valid: got %b want 1", is_valid); end
        rst = 1'b1; #1;
        compared++; if (active !== 4'b0000) begin mismatched++; $display("FAIL rm_async_active: got %b want 0000", active); end
        compared++; if (is_valid !== 1'b0) begin mismatched++; $display("FAIL rm_async_valid: got %b want 0", is_valid); end
        compared++; if (data !== flit_t'('0)) begin mismatched++; $display("FAIL rm_async_data: got %h want 0", data); end
        compared++; if (grant !== 4'b0000) begin mismatched++; $display("FAIL rm_async_grant: got %b want 0000", grant); end
        next_cycle(); rst = 1'b0; flit[0] = mk(HEAD, 16'h0E10); req = 4'b0001; #1;
        compared++; if (grant !== 4'b0001) begin mismatched++; $display("FAIL rm_new_head_grant: got %b want 0001", grant); end
        next_cycle(); req = '0; #1;
        compared++; if (active[0] !== 1'b1) begin mismatched++; $display("FAIL rm_new_active: got %b want 1", active[0]); end
        compared++; if (data !== mk(HEAD, 16'h0E10)) begin mismatched++; $display("FAIL rm_new_data: got %h want %h", data, mk(HEAD, 16'h0E10)); end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_headtail_holdoff();
        test_on_off();
        test_round_robin();
        test_alloc();
        test_protocol_error();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/output_link_scheduler.md
Name: output_link_scheduler

Overview:
- Per-output-port scheduler that shares one router-to-router link among the VC_NUM local output-side VCs.
- Selects one eligible VC per cycle and drives the link's upstream side (flit plus valid).
- Gates head flits on the downstream VC's allocatable status and all flits on its on/off status.
- Tracks the per-VC packet state (wormhole lock) and a post-tail holdoff so a VC is never double-allocated.

Parameters:
- VC_NUM, noc_pkg::VC_NUM: number of virtual channels. Local VC v maps 1:1 to downstream VC v.
- ALLOC_HOLDOFF, 2: cycles after a TAIL/HEADTAIL is sent on VC v during which a new head on v is blocked. Legal range 0..7.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_i  in  VC_NUM  VC v has a flit available at flit_i[v]
- flit_i  in  VC_NUM x flit_t  head-of-queue flit per VC
- grant_o  out  VC_NUM  one-hot/zero; combinational pop strobe to VC v's buffer, same cycle as selection
- data_o  out  flit_t  registered flit to the link (upstream.data)
- is_valid_o  out  1  registered valid (upstream.is_valid)
- is_on_off_i  in  VC_NUM  downstream VC can accept flits (upstream.is_on_off)
- is_allocatable_i  in  VC_NUM  downstream VC free for a new packet (upstream.is_allocatable)
- active_o  out  VC_NUM  debug: VC v is mid-packet

Behaviour:
- Reset (async, rst=1):
  - is_valid_o=0, data_o='0, grant_o=0, active_o=0.
  - All holdoff counters=0; round-robin pointer=0.
  - All state is cleared immediately, even mid-packet. The upstream buffers are reset by the same rst.
- Per-VC state: IDLE / ACTIVE, plus a holdoff counter hcnt[v] (3 bits).
- Eligibility (combinational):
  - elig[v] = req_i[v] & is_on_off_i[v] & (ACTIVE ? 1 : (label∈{HEAD,HEADTAIL} & is_allocatable_i[v] & hcnt[v]==0)).
  - An IDLE VC presenting BODY or TAIL is a protocol error: it is never eligible, and a simulation assertion fires.
- Arbitration:
  - Round-robin over elig, starting search at the pointer.
  - On a grant to v, the pointer becomes (v+1) mod VC_NUM. With no grant, the pointer holds.
  - At most one grant per cycle.
- Output: registered, 1-cycle latency. The grant in cycle N gives data_o=flit_i[v] and is_valid_o=1 in cycle N+1. With no grant, is_valid_o=0 and data_o holds its last value.
- State transitions, on grant to v:
  - HEAD: IDLE→ACTIVE.
  - BODY: stay ACTIVE.
  - TAIL: ACTIVE→IDLE, hcnt[v]=ALLOC_HOLDOFF.
  - HEADTAIL: stay IDLE, hcnt[v]=ALLOC_HOLDOFF.
- Holdoff counter: hcnt[v] decrements by 1 each cycle while nonzero. It saturates at 0 and never wraps.
- Interleaving: flits of different VCs may interleave freely on the link; each VC's packet stays contiguous within that VC.
- Simultaneous events:
  - is_on_off_i[v] falling in the same cycle as a request blocks v that cycle; no flit is lost.
  - Downstream provides at least 1 cycle of on/off margin.
  - The grant and the hcnt reload on the same VC in the same cycle are consistent, because hcnt is loaded only on TAIL/HEADTAIL grants.
- Starvation freedom: any continuously eligible VC is granted within VC_NUM cycles.

Decomposition:
- noc_pkg already owns flit_t, flit_label_t {HEAD, BODY, TAIL, HEADTAIL} and VC_NUM.
- Add to noc_pkg: ALLOC_HOLDOFF_DEFAULT=2 and typedef vc_state_t {VC_IDLE, VC_ACTIVE}.
- One sub-module: rr_arbiter #(N) (request vector in, one-hot grant out, internal pointer, advance strobe).
- The top level instantiates rr_arbiter once and drives the router2router upstream modport from data_o and is_valid_o.

Test Plan:
- Single HEADTAIL on VC0:
  - Stimulus: req_i=0001 with on_off/alloc all 1.
  - Response: grant_o=0001 in cycle N; is_valid_o=1 and data_o=that flit in N+1; VC0 stays IDLE.
  - With the head held at VC0, the next grant comes at N+3 (ALLOC_HOLDOFF=2).
- 4-flit packet on VC1 with is_on_off_i[1] dropped for 3 cycles after the HEAD:
  - Response: HEAD sent; BODY waits exactly 3 cycles; active_o[1] stays 1 throughout; TAIL returns it to 0.
- All 4 VCs request HEADTAIL continuously, VC_NUM=4:
  - Response: grants 0,1,2,3,0,… round-robin, one per cycle.
  - is_valid_o is continuously 1 except where blocked by holdoff.
- HEAD on VC2 with is_allocatable_i[2]=0:
  - Response: no grant. Then raise to 1 → grant next evaluation cycle.
  - BODY flits afterwards proceed even after is_allocatable_i[2] drops.
- IDLE VC3 presents BODY:
  - Response: never granted; assertion fires; other VCs unaffected.
- rst pulsed for 1 cycle mid-packet on VC0:
  - Response: active_o=0, is_valid_o=0 immediately (asynchronous).
  - A subsequent HEAD on VC0 is accepted normally.
